// File: rtl/usb_clock_endp_if.sv
// SIE IN-endpoint handshake between the clock endpoint (master) and usb_sie (slave).
interface usb_clock_endp_if;
    logic       in_req;
    logic       in_ack;
    logic [7:0] endpi_data;
    logic       endpi_valid;
    logic       endpi_crc16;
    logic       endpi_ready;

    // Endpoint side: produces the byte stream, consumes tokens and ready.
    modport master (
        output endpi_data,
        output endpi_valid,
        output endpi_crc16,
        input  endpi_ready,
        input  in_req,
        input  in_ack
    );

    // SIE side: issues tokens and ready, consumes the byte stream.
    modport slave (
        input  endpi_data,
        input  endpi_valid,
        input  endpi_crc16,
        output endpi_ready,
        output in_req,
        output in_ack
    );
endinterface

// File: rtl/usb_clock_endp.sv
// IN endpoint that serves a coherent DCF77 date/time snapshot as an 8-byte packet.
// The snapshot is kept across host retries so a NAKed/lost packet is resent unchanged.
module usb_clock_endp #(
    parameter int unsigned PKT_LEN = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              year,
    input  logic [7:0]              month,
    input  logic [7:0]              day,
    input  logic [2:0]              day_of_week,
    input  logic [7:0]              hour,
    input  logic [7:0]              minute,
    input  logic [7:0]              second,
    input  logic                    dcf77_sync,
    input  logic                    dcf77_error,
    usb_clock_endp_if.master        endp,
    output logic                    busy,
    output logic [7:0]              seq
);

    localparam int unsigned IW = $clog2(PKT_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SNAP     = 2'd1,
        SEND     = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t                  state;
    logic [PKT_LEN-1:0][7:0] snap;
    logic [IW-1:0]           idx;
    logic [TW-1:0]           tcnt;

    logic                    accept_c;
    logic                    last_c;
    logic [IW-1:0]           idx_nxt_c;
    logic                    stall_limit_c;

    // Byte handshake and index bookkeeping helpers.
    assign accept_c      = endp.endpi_valid && endp.endpi_ready;
    assign last_c        = (idx == IW'(PKT_LEN - 1));
    assign idx_nxt_c     = idx + IW'(1);
    assign stall_limit_c = (tcnt == TW'(TIMEOUT - 1));

    // Endpoint FSM: snapshot, stream bytes with stall timeout, wait for host ACK or retry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            snap             <= '0;
            idx              <= '0;
            tcnt             <= '0;
            seq              <= '0;
            busy             <= 1'b0;
            endp.endpi_data  <= '0;
            endp.endpi_valid <= 1'b0;
            endp.endpi_crc16 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (endp.in_req) begin
                        state <= SNAP;
                        busy  <= 1'b1;
                    end
                end

                SNAP: begin
                    // All fields captured on one edge so the packet is coherent.
                    snap             <= {seq, second, minute, hour,
                                         {dcf77_sync, dcf77_error, 3'b000, day_of_week},
                                         day, month, year};
                    idx              <= '0;
                    tcnt             <= '0;
                    endp.endpi_data  <= year;
                    endp.endpi_valid <= 1'b1;
                    endp.endpi_crc16 <= (PKT_LEN == 1);
                    state            <= SEND;
                end

                SEND: begin
                    if (accept_c) begin
                        tcnt <= '0;
                        if (last_c) begin
                            endp.endpi_data  <= '0;
                            endp.endpi_valid <= 1'b0;
                            endp.endpi_crc16 <= 1'b0;
                            state            <= WAIT_ACK;
                        end else begin
                            idx              <= idx_nxt_c;
                            endp.endpi_data  <= snap[idx_nxt_c];
                            endp.endpi_crc16 <= (idx_nxt_c == IW'(PKT_LEN - 1));
                        end
                    end else if (stall_limit_c) begin
                        // SIE stopped draining: give up, host will re-issue IN.
                        endp.endpi_data  <= '0;
                        endp.endpi_valid <= 1'b0;
                        endp.endpi_crc16 <= 1'b0;
                        idx              <= '0;
                        tcnt             <= '0;
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                WAIT_ACK: begin
                    // ACK takes priority over a simultaneous retry token.
                    if (endp.in_ack) begin
                        seq   <= seq + 8'd1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (endp.in_req) begin
                        idx              <= '0;
                        tcnt             <= '0;
                        endp.endpi_data  <= snap[0];
                        endp.endpi_valid <= 1'b1;
                        endp.endpi_crc16 <= (PKT_LEN == 1);
                        state            <= SEND;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_clock_endp.sv
// Directed plus randomized bench for usb_clock_endp against a packet-level reference model.
module tb_usb_clock_endp;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] year, month, day, hour, minute, second;
    logic [2:0] day_of_week;
    logic       dcf77_sync, dcf77_error;
    logic       busy;
    logic [7:0] seq;

    usb_clock_endp_if ifc ();

    usb_clock_endp #(
        .PKT_LEN (8),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .year        (year),
        .month       (month),
        .day         (day),
        .day_of_week (day_of_week),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .dcf77_sync  (dcf77_sync),
        .dcf77_error (dcf77_error),
        .endp        (ifc.master),
        .busy        (busy),
        .seq         (seq)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         model_seq = 0;
    int         rx_cycles = 0;
    logic [7:0] exp_pkt [8];
    logic [7:0] got_d [$];
    logic       got_c [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packet from the layout rule, using the inputs present at snapshot time.
    task automatic snap_model();
        exp_pkt[0] = year;
        exp_pkt[1] = month;
        exp_pkt[2] = day;
        exp_pkt[3] = {dcf77_sync, dcf77_error, 3'b000, day_of_week};
        exp_pkt[4] = hour;
        exp_pkt[5] = minute;
        exp_pkt[6] = second;
        exp_pkt[7] = 8'(model_seq);
    endtask

    task automatic rand_time();
        year        = 8'($urandom);
        month       = 8'($urandom);
        day         = 8'($urandom);
        hour        = 8'($urandom);
        minute      = 8'($urandom);
        second      = 8'($urandom);
        day_of_week = 3'($urandom_range(1, 7));
        dcf77_sync  = 1'($urandom);
        dcf77_error = 1'($urandom);
    endtask

    task automatic pulse_req();
        ifc.in_req = 1'b1;
        @(negedge clk);
        ifc.in_req = 1'b0;
    endtask

    task automatic pulse_ack();
        ifc.in_ack = 1'b1;
        @(negedge clk);
        ifc.in_ack = 1'b0;
        model_seq = (model_seq + 1) % 256;
        chk("ack_seq", seq, 32'(model_seq));
        chk("ack_busy", busy, 0);
    endtask

    // Drain n bytes with a ready pattern (0: always, 1: 1,0,0 repeating, 2: random).
    task automatic recv(input int mode, input int budget, input int n);
        int         cyc;
        logic       r;
        logic       held;
        logic [7:0] hd;
        logic       hc;
        cyc  = 0;
        held = 1'b0;
        hd   = '0;
        hc   = 1'b0;
        got_d.delete();
        got_c.delete();
        while (got_d.size() < n && cyc < budget) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            ifc.endpi_ready = r;
            if (ifc.endpi_valid) begin
                if (held) begin
                    chk("stable_data", ifc.endpi_data, hd);
                    chk("stable_crc", ifc.endpi_crc16, hc);
                end
                if (r) begin
                    got_d.push_back(ifc.endpi_data);
                    got_c.push_back(ifc.endpi_crc16);
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = ifc.endpi_data;
                    hc   = ifc.endpi_crc16;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rx_cycles = cyc;
        chk("rx_count", got_d.size(), 32'(n));
    endtask

    task automatic check_pkt(input string tag);
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_d[i], exp_pkt[i]);
            chk($sformatf("%s_crc%0d", tag, i), got_c[i], (i == 7) ? 1 : 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int stalls;

        reset           = 1'b1;
        ifc.in_req      = 1'b0;
        ifc.in_ack      = 1'b0;
        ifc.endpi_ready = 1'b0;
        year = 8'h24; month = 8'h05; day = 8'h17; day_of_week = 3'd5;
        hour = 8'h13; minute = 8'h45; second = 8'h09;
        dcf77_sync = 1'b1; dcf77_error = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_valid", ifc.endpi_valid, 0);
        chk("rst_data", ifc.endpi_data, 0);
        chk("rst_crc", ifc.endpi_crc16, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq", seq, 0);
        reset = 1'b0;
        @(negedge clk);

        // ACK while idle must not count.
        ifc.in_ack = 1'b1;
        @(negedge clk);
        ifc.in_ack = 1'b0;
        chk("idle_ack_seq", seq, 0);
        chk("idle_ack_busy", busy, 0);

        // 1: basic packet, latency and back-to-back streaming.
        snap_model();
        pulse_req();
        chk("t1_lat_valid_c1", ifc.endpi_valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_lat_valid_c2", ifc.endpi_valid, 1);
        chk("t1_first_byte", ifc.endpi_data, 8'h24);
        recv(0, 40, 8);
        chk("t1_cycles", rx_cycles, 8);
        check_pkt("t1");
        chk("t1_b3", exp_pkt[3], 8'h85);
        chk("t1_wait_valid", ifc.endpi_valid, 0);
        chk("t1_wait_crc", ifc.endpi_crc16, 0);
        chk("t1_wait_busy", busy, 1);
        pulse_ack();
        chk("t1_seq1", seq, 1);

        // 2: input change mid-packet is invisible; retry resends identical bytes.
        snap_model();
        pulse_req();
        @(negedge clk);
        second = 8'h10;
        recv(0, 40, 8);
        check_pkt("t2");
        chk("t2_b6", got_d[6], 8'h09);
        pulse_req();
        chk("t2_retry_seq", seq, 32'(model_seq));
        recv(0, 40, 8);
        check_pkt("t2r");
        pulse_ack();

        // 3: ready pattern 1,0,0 with stability checks.
        rand_time();
        snap_model();
        pulse_req();
        recv(1, 100, 8);
        check_pkt("t3");
        pulse_ack();

        // 4: stall after byte 2 until timeout abort, then fresh snapshot.
        rand_time();
        snap_model();
        pulse_req();
        recv(0, 40, 3);
        ifc.endpi_ready = 1'b0;
        chk("t4_hold_byte3", ifc.endpi_data, exp_pkt[3]);
        stalls = 0;
        while (ifc.endpi_valid && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        chk("t4_stalls", stalls, TO);
        chk("t4_valid", ifc.endpi_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_seq", seq, 32'(model_seq));
        rand_time();
        snap_model();
        pulse_req();
        recv(0, 40, 8);
        check_pkt("t4n");
        pulse_ack();

        // Randomized packets with random ready and occasional retries until seq reaches 255.
        while (model_seq != 255) begin
            rand_time();
            snap_model();
            pulse_req();
            recv(2, 200, 8);
            check_pkt("rnd");
            if ($urandom_range(0, 3) == 0) begin
                rand_time();
                pulse_req();
                recv(2, 200, 8);
                check_pkt("rnd_retry");
            end
            pulse_ack();
        end

        // 5: seq wrap, then ACK and IN in the same cycle.
        chk("t5_seq255", seq, 255);
        rand_time();
        snap_model();
        pulse_req();
        recv(0, 40, 8);
        check_pkt("t5");
        pulse_ack();
        chk("t5_wrap", seq, 0);
        rand_time();
        snap_model();
        pulse_req();
        recv(0, 40, 8);
        check_pkt("t5b");
        ifc.in_ack = 1'b1;
        ifc.in_req = 1'b1;
        @(negedge clk);
        ifc.in_ack = 1'b0;
        ifc.in_req = 1'b0;
        model_seq = (model_seq + 1) % 256;
        chk("t5_both_seq", seq, 32'(model_seq));
        chk("t5_both_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_resend", ifc.endpi_valid, 0);
        chk("t5_idle_busy", busy, 0);

        // 6: async reset at index 4, then clean restart.
        rand_time();
        snap_model();
        pulse_req();
        recv(0, 40, 4);
        ifc.endpi_ready = 1'b0;
        chk("t6_at_idx4", ifc.endpi_data, exp_pkt[4]);
        reset = 1'b1;
        #1;
        chk("t6_valid", ifc.endpi_valid, 0);
        chk("t6_data", ifc.endpi_data, 0);
        chk("t6_crc", ifc.endpi_crc16, 0);
        chk("t6_busy", busy, 0);
        chk("t6_seq", seq, 0);
        @(negedge clk);
        reset = 1'b0;
        model_seq = 0;
        @(negedge clk);
        rand_time();
        snap_model();
        pulse_req();
        recv(0, 40, 8);
        check_pkt("t6");
        chk("t6_b7", got_d[7], 0);
        pulse_ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
